// File: rtl/mult_div_seq.sv
// mult_div_seq: multicycle signed multiply / divide unit for the MIPS mult and div
// instructions. It runs one radix-2 iteration per clock over WIDTH cycles and writes the
// HI/LO pair that mfhi/mflo read.
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Iteration datapath and result-sign fixup.
  // For mult, prod holds {partial sum, remaining multiplier bits} and mcand is |A|.
  // For div, prod holds {partial remainder, dividend/quotient bits} and mcand is |B|.
  logic [WIDTH:0]     mult_sum;
  logic [2*WIDTH-1:0] mult_step;
  logic [WIDTH:0]     div_shifted;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] mult_signed;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Compute one multiply step, one divide step and the absolute-value inputs every cycle;
  // the FSM below decides which of them to commit.
  always_comb begin
    mult_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mult_step   = {mult_sum, prod_q[WIDTH-1:1]};

    div_shifted = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_diff    = div_shifted - {1'b0, mcand_q};
    if (div_shifted >= {1'b0, mcand_q}) begin
      div_step = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    end else begin
      div_step = {div_shifted[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    end

    mult_signed = neg_res_q ? (~mult_step + 1'b1) : mult_step;
    div_quo     = neg_res_q ? (~div_step[WIDTH-1:0] + 1'b1) : div_step[WIDTH-1:0];
    div_rem     = neg_rem_q ? (~div_step[2*WIDTH-1:WIDTH] + 1'b1)
                            : div_step[2*WIDTH-1:WIDTH];

    a_neg = a_in[WIDTH-1];
    b_neg = b_in[WIDTH-1];
    a_mag = a_neg ? (~a_in + 1'b1) : a_in;
    b_mag = b_neg ? (~b_in + 1'b1) : b_in;
  end

  // Next-state logic: accept a request in IDLE, iterate in RUN, pulse done in DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = op;
          cnt_d      = '0;
          div_zero_d = 1'b0;
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          if (op) begin
            mcand_d = b_mag;
            prod_d  = {{WIDTH{1'b0}}, a_mag};
          end else begin
            mcand_d = a_mag;
            prod_d  = {{WIDTH{1'b0}}, b_mag};
          end
          if (op && (b_in == '0)) begin
            div_zero_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_d  = cnt_q + 1'b1;
        prod_d = op_q ? div_step : mult_step;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          if (op_q) begin
            hi_d = div_rem;
            lo_d = div_quo;
          end else begin
            hi_d = mult_signed[2*WIDTH-1:WIDTH];
            lo_d = mult_signed[WIDTH-1:0];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      mcand_q    <= '0;
      prod_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign div_zero = div_zero_q & (state_q == S_DONE);
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: scoreboard bench for mult_div_seq. Expected HI/LO/div_zero and the
// edge at which done should appear are computed from 64-bit signed arithmetic when a
// request is issued; a monitor pops and compares whenever done is high.
module tb_mult_div_seq;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  mult_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned due;
  } exp_t;

  exp_t        sbq[$];
  int          compared = 0;
  int          mismatched = 0;
  int unsigned edge_cnt = 0;
  int          done_seen = 0;
  logic        busy_seen = 1'b0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  // Count rising edges so the monitor can check done latency.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse and checks the result.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (busy === 1'b1) busy_seen = 1'b1;
    if (done === 1'b1) begin
      done_seen++;
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done: got done=1 at edge %0d, expected no pending op", edge_cnt);
      end else begin
        e = sbq.pop_front();
        checkOutput("hi_out", {32'h0, hi_out}, {32'h0, e.hi});
        checkOutput("lo_out", {32'h0, lo_out}, {32'h0, e.lo});
        checkOutput("div_zero", {63'h0, div_zero}, {63'h0, e.dz});
        checkOutput("latency", {32'h0, edge_cnt}, {32'h0, e.due});
      end
    end
  end

  // Issue one request: compute its expected outcome, then pulse start for one cycle.
  task automatic applyStimulus(input logic o, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    longint r;
    @(negedge clk);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    if (!o) begin
      r = sa * sb;
      model_hi = r[63:32];
      model_lo = r[31:0];
      e.due = edge_cnt + W + 1;
    end else if (b == 32'h0) begin
      e.dz = 1'b1;
      e.due = edge_cnt + 1;
    end else begin
      r = sa / sb;
      model_lo = r[31:0];
      r = sa % sb;
      model_hi = r[31:0];
      e.due = edge_cnt + W + 1;
    end
    e.hi = model_hi;
    e.lo = model_lo;
    sbq.push_back(e);
    start = 1'b1;
    op = o;
    a_in = a;
    b_in = b;
    @(negedge clk);
    start = 1'b0;
    op = 1'($urandom);
    a_in = $urandom;
    b_in = $urandom;
  endtask

  // Bounded wait for the scoreboard to drain.
  task automatic waitDone(input string name);
    int guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL timeout_%s: got %0d pending after %0d cycles, expected 0", name, sbq.size(), guard);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin : stim
    int snap;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        ro;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {63'h0, busy}, 64'h0);
    checkOutput("rst_done", {63'h0, done}, 64'h0);
    checkOutput("rst_div_zero", {63'h0, div_zero}, 64'h0);
    checkOutput("rst_hi", {32'h0, hi_out}, 64'h0);
    checkOutput("rst_lo", {32'h0, lo_out}, 64'h0);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases: signed mult, most-negative squared, signed div, div overflow corner.
    applyStimulus(1'b0, 32'd7, 32'hFFFF_FFFD);
    waitDone("mult_neg");
    applyStimulus(1'b0, 32'h8000_0000, 32'h8000_0000);
    waitDone("mult_min");
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
    waitDone("div_neg");
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone("div_ovf");

    // Divide by zero: single-cycle, HI/LO preserved, busy never asserted.
    busy_seen = 1'b0;
    applyStimulus(1'b1, 32'd5, 32'd0);
    waitDone("div_zero");
    checkOutput("dz_busy_never", {63'h0, busy_seen}, 64'h0);

    // A start pulse during RUN is ignored.
    snap = done_seen;
    applyStimulus(1'b0, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op = 1'b1;
    a_in = 32'd9;
    b_in = 32'd3;
    @(negedge clk);
    start = 1'b0;
    waitDone("ignore_start");
    repeat (40) @(negedge clk);
    checkOutput("done_count", 64'(done_seen - snap), 64'd1);

    // Reset in the middle of a divide aborts it and clears HI/LO.
    applyStimulus(1'b1, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    checkOutput("abort_busy", {63'h0, busy}, 64'h0);
    checkOutput("abort_done", {63'h0, done}, 64'h0);
    checkOutput("abort_hi", {32'h0, hi_out}, 64'h0);
    checkOutput("abort_lo", {32'h0, lo_out}, 64'h0);
    reset = 1'b1;
    applyStimulus(1'b0, 32'd2, 32'd3);
    waitDone("after_abort");

    // Randomized mult/div with a bias toward boundary operands.
    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom);
      ra = pickOperand();
      rb = pickOperand();
      applyStimulus(ro, ra, rb);
      waitDone("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
